// File: rtl/risky_alu_arbiter.sv
// risky_alu_arbiter
// Shares one registered risky_alu between two requesters. Each requester
// hands over an operation on a valid/ready handshake; at most one
// operation is issued to the ALU per cycle, with round-robin priority on
// ties. The ALU result comes back one cycle after issue and is parked in a
// one-entry response buffer per requester, which the consumer drains
// through its own valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock shared with the ALU, async active-low reset
//   req0_* / req1_*            request handshake: valid, ready, mode, a, b
//   rsp0_* / rsp1_*            response handshake: valid, ready, data
//   alu_mode, alu_a, alu_b     operands driven to the ALU
//   alu_c                      registered ALU result, valid one cycle after issue

module risky_alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_mode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_mode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,

   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,

   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,

   output logic [3:0]       alu_mode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_c
);

   logic             inflight0;
   logic             inflight1;
   logic             full0;
   logic             full1;
   logic             prio;
   logic [WIDTH-1:0] buf0;
   logic [WIDTH-1:0] buf1;

   logic             elig0;
   logic             elig1;
   logic             grant0;
   logic             grant1;

   // A requester may issue only when it has nothing in the ALU and its
   // response buffer is either empty or being drained this very cycle, so
   // the result arriving next cycle always has somewhere to land.
   always_comb begin
      elig0 = req0_valid && !inflight0 && (!full0 || rsp0_ready);
      elig1 = req1_valid && !inflight1 && (!full1 || rsp1_ready);
   end

   // Round-robin pick. The grant is gated by rst_n so nothing is accepted
   // while the block is held in reset.
   always_comb begin
      grant0 = rst_n && elig0 && (!elig1 || !prio);
      grant1 = rst_n && elig1 && (!elig0 ||  prio);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Idle cycles still present requester 0's fields; the ALU computes
   // something, but no inflight flag is set so the result is discarded.
   always_comb begin
      if (grant1) begin
         alu_mode = req1_mode;
         alu_a    = req1_a;
         alu_b    = req1_b;
      end else begin
         alu_mode = req0_mode;
         alu_a    = req0_a;
         alu_b    = req0_b;
      end
   end

   assign rsp0_valid = full0;
   assign rsp0_data  = buf0;
   assign rsp1_valid = full1;
   assign rsp1_data  = buf1;

   // Issue tracking and priority. A requester that is in flight is never
   // eligible, so the inflight flag simply follows this cycle's grant.
   // Priority flips to the other requester after every grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight0 <= 1'b0;
         inflight1 <= 1'b0;
         prio      <= 1'b0;
      end else begin
         inflight0 <= grant0;
         inflight1 <= grant1;
         if (grant0) begin
            prio <= 1'b1;
         end else if (grant1) begin
            prio <= 1'b0;
         end
      end
   end

   // Response buffers. A capture takes precedence over a drain in the same
   // cycle: the old result leaves and the new one is held in its place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full0 <= 1'b0;
         full1 <= 1'b0;
         buf0  <= '0;
         buf1  <= '0;
      end else begin
         if (inflight0) begin
            buf0  <= alu_c;
            full0 <= 1'b1;
         end else if (full0 && rsp0_ready) begin
            full0 <= 1'b0;
         end

         if (inflight1) begin
            buf1  <= alu_c;
            full1 <= 1'b1;
         end else if (full1 && rsp1_ready) begin
            full1 <= 1'b0;
         end
      end
   end

endmodule
